// File: rtl/decode_stage_nw.sv
// N-lane decode stage: per-lane decoders, oldest-inconsistency kill and redirect,
// output register plus one-bundle skid, and a fetch-shadow discard window.

module decoder #(
   parameter int ADDR_WIDTH = 32,
   parameter int DEC_W      = 128
) (
   input  logic [31:0]           instr,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic                  guesses_branch,
   input  logic                  prediction,
   output logic [DEC_W-1:0]      pkt,
   output logic                  inc,
   output logic [ADDR_WIDTH-1:0] new_pc
);
   logic [6:0]            opcode;
   logic                  is_jal;
   logic                  is_jalr;
   logic                  is_branch;
   logic [31:0]           imm;
   logic [66:0]           fields;
   logic [ADDR_WIDTH-1:0] seq_pc;

   always_comb begin
      opcode    = instr[6:0];
      is_jal    = (opcode == 7'h6F);
      is_jalr   = (opcode == 7'h67);
      is_branch = (opcode == 7'h63);
      if (is_jal)
         imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      else if (is_branch)
         imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      else
         imm = {{20{instr[31]}}, instr[31:20]};
      fields = {is_branch, is_jalr, is_jal, imm, instr};
      pkt    = DEC_W'(fields);
      seq_pc = pc + ADDR_WIDTH'(4);
      // JAL target is known here; branch/JALR outcomes are not, so only
      // a non-control instruction that fetch steered is also inconsistent.
      if (is_jal) begin
         inc    = !(guesses_branch && prediction);
         new_pc = pc + ADDR_WIDTH'($signed(imm));
      end else if (is_jalr || is_branch) begin
         inc    = 1'b0;
         new_pc = seq_pc;
      end else begin
         inc    = guesses_branch;
         new_pc = seq_pc;
      end
   end
endmodule

module decode_stage_nw #(
   parameter int LANES      = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DEC_W      = 128,
   parameter int SHADOW     = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic [LANES-1:0]              in_valid,
   input  logic [LANES*32-1:0]           in_instr,
   input  logic [LANES*ADDR_WIDTH-1:0]   in_pc,
   input  logic [LANES-1:0]              in_guesses_branch,
   input  logic [LANES-1:0]              in_prediction,
   output logic                          in_ready,
   output logic [LANES-1:0]              out_valid,
   output logic [LANES*DEC_W-1:0]        out_pkt,
   output logic [LANES*ADDR_WIDTH-1:0]   out_pc,
   input  logic                          out_ready,
   output logic                          fb_valid,
   output logic [ADDR_WIDTH-1:0]         fb_pc
);
   logic [LANES*DEC_W-1:0]      dec_pkt;
   logic [LANES-1:0]            dec_inc;
   logic [ADDR_WIDTH-1:0]       dec_npc [LANES];

   logic [LANES-1:0]            out_valid_q, out_valid_d;
   logic [LANES*DEC_W-1:0]      out_pkt_q, out_pkt_d;
   logic [LANES*ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
   logic [LANES-1:0]            skid_valid_q, skid_valid_d;
   logic [LANES*DEC_W-1:0]      skid_pkt_q, skid_pkt_d;
   logic [LANES*ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
   logic [2:0]                  shadow_q, shadow_d;
   logic                        fb_valid_q, fb_valid_d;
   logic [ADDR_WIDTH-1:0]       fb_pc_q, fb_pc_d;

   logic [LANES-1:0]            kept_valid;
   logic                        found;
   logic [ADDR_WIDTH-1:0]       k_pc;
   logic                        skid_full, out_full, in_shadow;
   logic                        accept, store, redirect, xfer;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      decoder #(.ADDR_WIDTH(ADDR_WIDTH), .DEC_W(DEC_W)) u_dec (
         .instr          (in_instr[g*32 +: 32]),
         .pc             (in_pc[g*ADDR_WIDTH +: ADDR_WIDTH]),
         .guesses_branch (in_guesses_branch[g]),
         .prediction     (in_prediction[g]),
         .pkt            (dec_pkt[g*DEC_W +: DEC_W]),
         .inc            (dec_inc[g]),
         .new_pc         (dec_npc[g])
      );
   end

   // Oldest valid inconsistent lane survives; every younger lane is killed.
   always_comb begin
      kept_valid = in_valid;
      found      = 1'b0;
      k_pc       = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (found)
            kept_valid[i] = 1'b0;
         else if (in_valid[i] && dec_inc[i]) begin
            found = 1'b1;
            k_pc  = dec_npc[i];
         end
      end
   end

   assign skid_full = |skid_valid_q;
   assign out_full  = |out_valid_q;
   assign in_shadow = (shadow_q != '0);
   assign in_ready  = !reset && !flush && (!skid_full || in_shadow);
   assign accept    = in_ready && (|in_valid);
   assign store     = accept && !in_shadow;
   assign redirect  = store && found;
   assign xfer      = out_full && out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_pkt_d    = out_pkt_q;
      out_pc_d     = out_pc_q;
      skid_valid_d = skid_valid_q;
      skid_pkt_d   = skid_pkt_q;
      skid_pc_d    = skid_pc_q;
      shadow_d     = shadow_q;
      fb_valid_d   = 1'b0;
      fb_pc_d      = fb_pc_q;
      if (reset || flush) begin
         out_valid_d  = '0;
         out_pkt_d    = '0;
         out_pc_d     = '0;
         skid_valid_d = '0;
         skid_pkt_d   = '0;
         skid_pc_d    = '0;
         shadow_d     = '0;
         fb_pc_d      = '0;
      end else begin
         if (in_shadow)
            shadow_d = shadow_q - 3'd1;
         // A full skid blocks new bundles outside the shadow, so the skid
         // draining and a bundle being stored never coincide.
         if (skid_full && xfer) begin
            out_valid_d  = skid_valid_q;
            out_pkt_d    = skid_pkt_q;
            out_pc_d     = skid_pc_q;
            skid_valid_d = '0;
         end else if (store && (!out_full || xfer)) begin
            out_valid_d = kept_valid;
            out_pkt_d   = dec_pkt;
            out_pc_d    = in_pc;
         end else if (store) begin
            skid_valid_d = kept_valid;
            skid_pkt_d   = dec_pkt;
            skid_pc_d    = in_pc;
         end else if (xfer) begin
            out_valid_d = '0;
         end
         if (redirect) begin
            fb_valid_d = 1'b1;
            fb_pc_d    = k_pc;
            shadow_d   = 3'(SHADOW);
         end
      end
   end

   always_ff @(posedge clk) begin
      out_valid_q  <= out_valid_d;
      out_pkt_q    <= out_pkt_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_pkt_q   <= skid_pkt_d;
      skid_pc_q    <= skid_pc_d;
      shadow_q     <= shadow_d;
      fb_valid_q   <= fb_valid_d;
      fb_pc_q      <= fb_pc_d;
   end

   assign out_valid = out_valid_q;
   assign out_pkt   = out_pkt_q;
   assign out_pc    = out_pc_q;
   assign fb_valid  = fb_valid_q;
   assign fb_pc     = fb_pc_q;
endmodule

// File: tb/tb_decode_stage_nw.sv
// Bench for decode_stage_nw: a 2-lane and a 4-lane instance checked every cycle
// against a queue-based model, plus directed literal expectations.

module tb_decode_stage_nw;
   localparam int SH = 1;
   localparam logic [31:0] NOP   = 32'h00000013;
   localparam logic [31:0] ADDI  = 32'h00500093;
   localparam logic [31:0] BEQ8  = 32'h00000463;
   localparam logic [31:0] JAL40 = 32'h040000EF;
   localparam logic [31:0] JAL80 = 32'h080000EF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, flush, out_ready;
   logic [3:0]  tv  [2];
   logic [31:0] ti  [2][4];
   logic [31:0] tp  [2][4];
   logic [3:0]  tg  [2];
   logic [3:0]  tpr [2];

   logic [1:0]   i2_valid, i2_gb, i2_pr;
   logic [63:0]  i2_instr, i2_pc;
   logic         o2_ready, o2_fbv;
   logic [1:0]   o2_valid;
   logic [255:0] o2_pkt;
   logic [63:0]  o2_pc;
   logic [31:0]  o2_fbpc;

   logic [3:0]   i4_valid, i4_gb, i4_pr;
   logic [127:0] i4_instr, i4_pc;
   logic         o4_ready, o4_fbv;
   logic [3:0]   o4_valid;
   logic [511:0] o4_pkt;
   logic [127:0] o4_pc;
   logic [31:0]  o4_fbpc;

   assign i2_valid = tv[0][1:0];
   assign i2_gb    = tg[0][1:0];
   assign i2_pr    = tpr[0][1:0];
   assign i2_instr = {ti[0][1], ti[0][0]};
   assign i2_pc    = {tp[0][1], tp[0][0]};
   assign i4_valid = tv[1];
   assign i4_gb    = tg[1];
   assign i4_pr    = tpr[1];
   assign i4_instr = {ti[1][3], ti[1][2], ti[1][1], ti[1][0]};
   assign i4_pc    = {tp[1][3], tp[1][2], tp[1][1], tp[1][0]};

   decode_stage_nw #(.LANES(2), .ADDR_WIDTH(32), .DEC_W(128), .SHADOW(SH)) dut2 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(i2_valid), .in_instr(i2_instr), .in_pc(i2_pc),
      .in_guesses_branch(i2_gb), .in_prediction(i2_pr), .in_ready(o2_ready),
      .out_valid(o2_valid), .out_pkt(o2_pkt), .out_pc(o2_pc), .out_ready(out_ready),
      .fb_valid(o2_fbv), .fb_pc(o2_fbpc));

   decode_stage_nw #(.LANES(4), .ADDR_WIDTH(32), .DEC_W(128), .SHADOW(SH)) dut4 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(i4_valid), .in_instr(i4_instr), .in_pc(i4_pc),
      .in_guesses_branch(i4_gb), .in_prediction(i4_pr), .in_ready(o4_ready),
      .out_valid(o4_valid), .out_pkt(o4_pkt), .out_pc(o4_pc), .out_ready(out_ready),
      .fb_valid(o4_fbv), .fb_pc(o4_fbpc));

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference meaning of one instruction given the fetch prediction.
   function automatic void dec(input logic [31:0] ins, input logic [31:0] pc,
                               input logic gb, input logic pr,
                               output logic [127:0] pkt, output logic inc,
                               output logic [31:0] npc);
      logic [31:0] imm;
      logic jal, jalr, br;
      jal  = ins[6:0] == 7'b1101111;
      jalr = ins[6:0] == 7'b1100111;
      br   = ins[6:0] == 7'b1100011;
      if (jal)     imm = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      else if (br) imm = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      else         imm = $signed(ins[31:20]);
      pkt = {61'd0, br, jalr, jal, imm, ins};
      npc = pc + 32'd4;
      inc = 1'b0;
      if (jal) begin
         npc = pc + imm;
         inc = !(gb && pr);
      end else if (!jalr && !br) begin
         inc = gb;
      end
   endfunction

   typedef struct packed {
      logic [3:0]        v;
      logic [3:0][127:0] pkt;
      logic [3:0][31:0]  pc;
   } bundle_t;

   bundle_t     mq    [2][2];
   int          mcnt  [2] = '{0, 0};
   int          msh   [2] = '{0, 0};
   logic        mfbv  [2] = '{1'b0, 1'b0};
   logic [31:0] mfbpc [2];

   // Model: storage is a FIFO of at most two bundles whose head is the output.
   always @(posedge clk) begin
      int n, k;
      logic [3:0] vin;
      logic rdy, acc, discard;
      bundle_t b;
      logic [127:0] pk;
      logic ic;
      logic [31:0] np, kpc;
      for (int d = 0; d < 2; d++) begin
         n = (d == 0) ? 2 : 4;
         if (reset || flush) begin
            mcnt[d] = 0;
            msh[d]  = 0;
            mfbv[d] = 1'b0;
         end else begin
            vin     = tv[d] & ((n == 2) ? 4'b0011 : 4'b1111);
            rdy     = (mcnt[d] < 2) || (msh[d] != 0);
            acc     = rdy && (vin != 4'd0);
            discard = msh[d] != 0;
            mfbv[d] = 1'b0;
            if (msh[d] > 0) msh[d] = msh[d] - 1;
            if (mcnt[d] > 0 && out_ready) begin
               mq[d][0] = mq[d][1];
               mcnt[d]  = mcnt[d] - 1;
            end
            if (acc && !discard) begin
               b   = '0;
               k   = n;
               kpc = '0;
               for (int l = 0; l < n; l++) begin
                  dec(ti[d][l], tp[d][l], tg[d][l], tpr[d][l], pk, ic, np);
                  b.pkt[l] = pk;
                  b.pc[l]  = tp[d][l];
                  if (k == n && vin[l] && ic) begin
                     k   = l;
                     kpc = np;
                  end
               end
               for (int l = 0; l < n; l++) b.v[l] = vin[l] && (l <= k);
               mq[d][mcnt[d]] = b;
               mcnt[d] = mcnt[d] + 1;
               if (k < n) begin
                  mfbv[d]  = 1'b1;
                  mfbpc[d] = kpc;
                  msh[d]   = SH;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      int n;
      logic [3:0] ev, av;
      logic ardy, afbv, erdy;
      logic [31:0] afbpc;
      for (int d = 0; d < 2; d++) begin
         n     = (d == 0) ? 2 : 4;
         ev    = (mcnt[d] > 0) ? mq[d][0].v : 4'd0;
         av    = (d == 0) ? {2'b00, o2_valid} : o4_valid;
         ardy  = (d == 0) ? o2_ready : o4_ready;
         afbv  = (d == 0) ? o2_fbv : o4_fbv;
         afbpc = (d == 0) ? o2_fbpc : o4_fbpc;
         erdy  = !reset && !flush && ((mcnt[d] < 2) || (msh[d] != 0));
         chk($sformatf("L%0d out_valid", n), av, ev);
         chk($sformatf("L%0d in_ready", n), ardy, erdy);
         chk($sformatf("L%0d fb_valid", n), afbv, mfbv[d]);
         if (mfbv[d]) chk($sformatf("L%0d fb_pc", n), afbpc, mfbpc[d]);
         for (int l = 0; l < n; l++) begin
            if (ev[l]) begin
               chk($sformatf("L%0d out_pkt[%0d]", n, l),
                   (d == 0) ? o2_pkt[l*128 +: 128] : o4_pkt[l*128 +: 128], mq[d][0].pkt[l]);
               chk($sformatf("L%0d out_pc[%0d]", n, l),
                   (d == 0) ? o2_pc[l*32 +: 32] : o4_pc[l*32 +: 32], mq[d][0].pc[l]);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      tv[0] = 4'd0;
      tv[1] = 4'd0;
      tg[0] = 4'd0;
      tg[1] = 4'd0;
      tpr[0] = 4'd0;
      tpr[1] = 4'd0;
   endtask

   task automatic put(input int d, input int l, input logic [31:0] ins,
                      input logic [31:0] pc, input logic gb, input logic pr);
      tv[d][l]  = 1'b1;
      ti[d][l]  = ins;
      tp[d][l]  = pc;
      tg[d][l]  = gb;
      tpr[d][l] = pr;
   endtask

   task automatic put2(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1);
      idle();
      put(0, 0, i0, pc, 1'b0, 1'b0);
      put(0, 1, i1, pc + 32'd4, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      out_ready = 1'b1;
      for (int d = 0; d < 2; d++)
         for (int l = 0; l < 4; l++) begin
            ti[d][l] = NOP;
            tp[d][l] = '0;
         end
      idle();
      tick();
      tick();
      chk("in_ready during reset", o2_ready, 1'b0);
      reset = 1'b0;
      #1;
      chk("in_ready after reset", o2_ready, 1'b1);
      chk("reset out_valid", o2_valid, 2'b00);
      chk("reset out_pkt", o2_pkt[127:0] | o2_pkt[255:128], 128'd0);
      chk("reset out_pc", o2_pc, 64'd0);
      chk("reset fb_pc", o2_fbpc, 32'd0);

      // streaming, one bundle per cycle
      for (int b = 0; b < 3; b++) begin
         put2(32'h100 + 32'(8 * b), ADDI, (b == 2) ? BEQ8 : NOP);
         if (b == 2) begin
            tg[0][1]  = 1'b1;
            tpr[0][1] = 1'b1;
         end
         tick();
         chk("stream out_valid", o2_valid, 2'b11);
         chk("stream out_pc0", o2_pc[31:0], 32'h100 + 32'(8 * b));
         chk("stream fb_valid", o2_fbv, 1'b0);
      end
      idle();
      tick();

      // unpredicted JAL in lane 0 kills lane 1
      put2(32'h200, JAL40, NOP);
      tick();
      chk("kill out_valid", o2_valid, 2'b01);
      chk("kill fb_valid", o2_fbv, 1'b1);
      chk("kill fb_pc", o2_fbpc, 32'h240);
      chk("kill pkt instr", o2_pkt[31:0], JAL40);
      out_ready = 1'b0;
      put2(32'h240, NOP, NOP);
      #1;
      chk("shadow in_ready", o2_ready, 1'b1);
      tick();
      chk("shadow out_valid", o2_valid, 2'b01);
      chk("shadow out_pc0", o2_pc[31:0], 32'h200);
      chk("shadow fb_valid", o2_fbv, 1'b0);
      idle();
      out_ready = 1'b1;
      tick();

      // backpressure: A held, B in skid, C refused until space
      out_ready = 1'b0;
      put2(32'h500, ADDI, NOP);
      tick();
      put2(32'h508, NOP, ADDI);
      tick();
      put2(32'h510, ADDI, ADDI);
      #1;
      chk("bp in_ready full", o2_ready, 1'b0);
      tick();
      chk("bp hold A", o2_pc[31:0], 32'h500);
      out_ready = 1'b1;
      tick();
      chk("bp then B", o2_pc[31:0], 32'h508);
      tick();
      chk("bp then C", o2_pc[31:0], 32'h510);
      idle();
      tick();
      chk("bp drained", o2_valid, 2'b00);

      // both lanes inconsistent: lane 0 wins
      put2(32'h300, JAL40, JAL80);
      tick();
      chk("dbl out_valid", o2_valid, 2'b01);
      chk("dbl fb_pc", o2_fbpc, 32'h340);
      idle();
      tick();
      chk("dbl fb pulse", o2_fbv, 1'b0);

      // flush while stalled with skid full and an inconsistent bundle present
      out_ready = 1'b0;
      put2(32'h600, NOP, NOP);
      tick();
      put2(32'h608, NOP, NOP);
      tick();
      put2(32'h610, JAL40, NOP);
      flush = 1'b1;
      #1;
      chk("flush in_ready", o2_ready, 1'b0);
      tick();
      flush = 1'b0;
      idle();
      #1;
      chk("flush out_valid", o2_valid, 2'b00);
      chk("flush fb_valid", o2_fbv, 1'b0);
      chk("flush in_ready after", o2_ready, 1'b1);
      put2(32'h700, NOP, NOP);
      tick();
      put2(32'h708, NOP, NOP);
      #1;
      chk("flush skid empty", o2_ready, 1'b1);
      tick();
      out_ready = 1'b1;
      idle();
      tick();
      tick();

      // fetch steered a plain ALU op
      put2(32'h800, NOP, NOP);
      tg[0][0] = 1'b1;
      tpr[0][0] = 1'b1;
      tick();
      chk("alu steer out_valid", o2_valid, 2'b01);
      chk("alu steer fb_pc", o2_fbpc, 32'h804);
      idle();
      tick();
      tick();

      // 4-lane instance
      for (int l = 0; l < 4; l++) put(1, l, ADDI, 32'h400 + 32'(4 * l), 1'b0, 1'b0);
      tick();
      chk("L4 out_valid full", o4_valid, 4'b1111);
      idle();
      for (int l = 0; l < 4; l++) put(1, l, (l == 2) ? JAL40 : NOP, 32'h410 + 32'(4 * l), 1'b0, 1'b0);
      tick();
      chk("L4 kill out_valid", o4_valid, 4'b0111);
      chk("L4 fb_valid", o4_fbv, 1'b1);
      chk("L4 fb_pc", o4_fbpc, 32'h458);
      idle();
      tick();
      chk("L4 fb pulse", o4_fbv, 1'b0);
      put(1, 0, NOP, 32'h420, 1'b0, 1'b0);
      put(1, 1, NOP, 32'h424, 1'b0, 1'b0);
      ti[1][2] = JAL40;
      tp[1][2] = 32'h428;
      tick();
      chk("L4 invalid inc out_valid", o4_valid, 4'b0011);
      chk("L4 invalid inc fb_valid", o4_fbv, 1'b0);
      idle();
      tick();
      tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
